// File: rtl/nested_index_gen_pkg.sv
// Shared types for the nested row/column index generator: FSM states and
// iteration modes.
package nested_index_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FULL walks every column of each row; UPPER walks only columns right of
  // the diagonal.
  typedef enum logic {
    FULL  = 1'b0,
    UPPER = 1'b1
  } mode_t;

endpackage : nested_index_gen_pkg

// File: rtl/nested_index_gen_if.sv
// Bundle of launch controls, loop bounds and the index-pair stream between
// the generator (slave) and its driver/consumer (master).
interface nested_index_gen_if #(
  parameter int SIZE_ADDR = 8
);

  logic                 i_start;
  logic                 i_abort;
  logic [SIZE_ADDR-1:0] i_num_rows;
  logic [SIZE_ADDR-1:0] i_num_cols;
  logic                 i_mode;
  logic                 i_ready;
  logic                 o_valid;
  logic [SIZE_ADDR-1:0] o_i;
  logic [SIZE_ADDR-1:0] o_j;
  logic                 o_last;
  logic                 o_busy;
  logic                 o_done;

  // A pair transfers on any rising edge with o_valid & i_ready. Once o_valid
  // is high, o_i/o_j/o_last hold until that transfer (or an abort/reset);
  // o_valid never depends combinationally on i_ready.
  modport slave (
    input  i_start,
    input  i_abort,
    input  i_num_rows,
    input  i_num_cols,
    input  i_mode,
    input  i_ready,
    output o_valid,
    output o_i,
    output o_j,
    output o_last,
    output o_busy,
    output o_done
  );

  modport master (
    output i_start,
    output i_abort,
    output i_num_rows,
    output i_num_cols,
    output i_mode,
    output i_ready,
    input  o_valid,
    input  o_i,
    input  o_j,
    input  o_last,
    input  o_busy,
    input  o_done
  );

endinterface : nested_index_gen_if

// File: rtl/nested_index_next.sv
// Successor of the current (i, j) pair and a flag saying whether the current
// pair is the final one of the run.
module nested_index_next
  import nested_index_gen_pkg::*;
#(
  parameter int SIZE_ADDR = 8
) (
  input  logic [SIZE_ADDR-1:0] cur_i,
  input  logic [SIZE_ADDR-1:0] cur_j,
  input  logic [SIZE_ADDR-1:0] num_rows,
  input  logic [SIZE_ADDR-1:0] num_cols,
  input  mode_t                mode,
  output logic [SIZE_ADDR-1:0] nxt_i,
  output logic [SIZE_ADDR-1:0] nxt_j,
  output logic                 last
);

  localparam int WX = SIZE_ADDR + 1;

  // One extra bit so i+2 / j+1 can exceed a bound of 2^SIZE_ADDR-1.
  logic [WX-1:0] i_x;
  logic [WX-1:0] j_x;
  logic [WX-1:0] rows_x;
  logic [WX-1:0] cols_x;
  logic [WX-1:0] j_inc;
  logic [WX-1:0] i_inc;
  logic [WX-1:0] j_upper;

  assign i_x     = {1'b0, cur_i};
  assign j_x     = {1'b0, cur_j};
  assign rows_x  = {1'b0, num_rows};
  assign cols_x  = {1'b0, num_cols};
  assign j_inc   = j_x + WX'(1);
  assign i_inc   = i_x + WX'(1);
  assign j_upper = i_x + WX'(2);

  // In UPPER mode a row that has no column right of the diagonal implies every
  // later row is empty too, so running out of columns ends the run outright.
  always_comb begin
    nxt_i = cur_i;
    nxt_j = cur_j;
    last  = 1'b0;
    if (j_inc < cols_x) begin
      nxt_j = j_inc[SIZE_ADDR-1:0];
    end else begin
      nxt_i = i_inc[SIZE_ADDR-1:0];
      if (mode == UPPER) begin
        nxt_j = j_upper[SIZE_ADDR-1:0];
        last  = (i_inc >= rows_x) || (j_upper >= cols_x);
      end else begin
        nxt_j = '0;
        last  = (i_inc >= rows_x);
      end
    end
  end

endmodule : nested_index_next

// File: rtl/nested_index_gen.sv
// Nested-loop index generator: streams (i, j) pairs over an R x C space (full
// or strictly-upper triangle) with valid/ready flow control.
module nested_index_gen
  import nested_index_gen_pkg::*;
#(
  parameter int SIZE_ADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  nested_index_gen_if.slave   bus,
  output state_t              o_state
);

  state_t               state_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic [SIZE_ADDR-1:0] i_q;
  logic [SIZE_ADDR-1:0] j_q;
  logic [SIZE_ADDR-1:0] rows_q;
  logic [SIZE_ADDR-1:0] cols_q;
  mode_t                mode_q;

  logic [SIZE_ADDR-1:0] nxt_i;
  logic [SIZE_ADDR-1:0] nxt_j;
  logic                 last_w;
  mode_t                start_mode;
  logic                 start_empty;
  logic [SIZE_ADDR-1:0] first_j;

  nested_index_next #(
    .SIZE_ADDR (SIZE_ADDR)
  ) u_next (
    .cur_i    (i_q),
    .cur_j    (j_q),
    .num_rows (rows_q),
    .num_cols (cols_q),
    .mode     (mode_q),
    .nxt_i    (nxt_i),
    .nxt_j    (nxt_j),
    .last     (last_w)
  );

  assign start_mode  = mode_t'(bus.i_mode);
  assign start_empty = (bus.i_num_rows == '0) || (bus.i_num_cols == '0) ||
                       ((start_mode == UPPER) && (bus.i_num_cols <= SIZE_ADDR'(1)));
  assign first_j     = (start_mode == UPPER) ? SIZE_ADDR'(1) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      mode_q  <= FULL;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            rows_q <= bus.i_num_rows;
            cols_q <= bus.i_num_cols;
            mode_q <= start_mode;
            busy_q <= 1'b1;
            if (start_empty) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              i_q     <= '0;
              j_q     <= first_j;
            end
          end
        end
        RUN: begin
          // Abort wins over a handshake landing on the same edge.
          if (bus.i_abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (valid_q && bus.i_ready) begin
            if (last_w) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              i_q <= nxt_i;
              j_q <= nxt_j;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_i     = i_q;
  assign bus.o_j     = j_q;
  assign bus.o_last  = valid_q & last_w;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign o_state     = state_q;

endmodule : nested_index_gen
